// File: rtl/bp_be_pkg.sv
// Shared types for the BE dispatch hazard detector: hazard-reason bit indices
// and the counter-width helper used to size latency/credit counters.
`ifndef BP_BE_CNT_W
`define BP_BE_CNT_W(max_val) (((max_val) < 1) ? 1 : $clog2((max_val) + 1))
`endif

package bp_be_pkg;

    typedef enum logic [1:0] {
        HAZ_RAW    = 2'd0,
        HAZ_WAW    = 2'd1,
        HAZ_CTRL   = 2'd2,
        HAZ_STRUCT = 2'd3
    } bp_be_haz_reason_e;

    localparam int HAZ_W = 4;

endpackage

// File: rtl/bp_be_scoreboard_detector_if.sv
// ISD <-> detector bundle: the offered instruction plus the permit/hazard reply.
interface bp_be_scoreboard_detector_if #(
    parameter int reg_addr_width_p = 5,
    parameter int max_lat_p        = 7
);
    localparam int lat_w_lp = (max_lat_p < 1) ? 1 : $clog2(max_lat_p + 1);

    logic                                 isd_v_i;
    logic [2:0][reg_addr_width_p-1:0]     isd_rs_addr_i;
    logic [1:0]                           isd_irs_v_i;
    logic [2:0]                           isd_frs_v_i;
    logic [reg_addr_width_p-1:0]          isd_rd_addr_i;
    logic                                 isd_iwb_v_i;
    logic                                 isd_fwb_v_i;
    logic [lat_w_lp-1:0]                  isd_lat_i;
    logic                                 isd_mem_v_i;
    logic                                 isd_fence_v_i;
    logic                                 isd_serial_v_i;
    logic                                 chk_dispatch_v_o;
    logic [3:0]                           haz_o;

    modport master (
        output isd_v_i, isd_rs_addr_i, isd_irs_v_i, isd_frs_v_i, isd_rd_addr_i,
               isd_iwb_v_i, isd_fwb_v_i, isd_lat_i, isd_mem_v_i, isd_fence_v_i,
               isd_serial_v_i,
        input  chk_dispatch_v_o, haz_o
    );

    modport slave (
        input  isd_v_i, isd_rs_addr_i, isd_irs_v_i, isd_frs_v_i, isd_rd_addr_i,
               isd_iwb_v_i, isd_fwb_v_i, isd_lat_i, isd_mem_v_i, isd_fence_v_i,
               isd_serial_v_i,
        output chk_dispatch_v_o, haz_o
    );

endinterface

// File: rtl/bp_be_reg_scoreboard.sv
// Per-register result-latency counters for one register file: load on write
// dispatch, count down otherwise, with three source lookups and one rd lookup.
module bp_be_reg_scoreboard #(
    parameter int addr_w_p   = 5,
    parameter int lat_w_p    = 3,
    parameter bit zero_reg_p = 1'b0
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     flush_i,
    input  logic                     ld_v_i,
    input  logic [addr_w_p-1:0]      ld_addr_i,
    input  logic [lat_w_p-1:0]       ld_lat_i,
    input  logic [2:0][addr_w_p-1:0] rs_addr_i,
    output logic [2:0]               rs_busy_o,
    input  logic [addr_w_p-1:0]      rd_addr_i,
    output logic [lat_w_p-1:0]       rd_cnt_o
);

    localparam int nreg_lp = 1 << addr_w_p;

    logic [nreg_lp-1:0][lat_w_p-1:0] cnt_q, cnt_d;

    // Load beats decrement; flush beats both; a hardwired-zero register never counts.
    always_comb begin
        for (int r = 0; r < nreg_lp; r++) begin
            cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - lat_w_p'(1) : '0;
            if (ld_v_i && (ld_addr_i == addr_w_p'(r)))
                cnt_d[r] = ld_lat_i;
            if (flush_i || (zero_reg_p && (r == 0)))
                cnt_d[r] = '0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) cnt_q <= '0;
        else            cnt_q <= cnt_d;
    end

    always_comb begin
        for (int i = 0; i < 3; i++)
            rs_busy_o[i] = (cnt_q[rs_addr_i[i]] != '0);
        rd_cnt_o = cnt_q[rd_addr_i];
    end

endmodule

// File: rtl/bp_be_scoreboard_detector.sv
// BE dispatch permit: int/FP latency scoreboards (RAW/WAW), serialisation and
// fence drain (control), memory credits and external readiness (structural).
module bp_be_scoreboard_detector
    import bp_be_pkg::*;
#(
    parameter int reg_addr_width_p = 5,
    parameter int max_lat_p        = 7,
    parameter int pipe_depth_p     = 4,
    parameter int credits_p        = 8,
    parameter int serial_stages_p  = 4
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic                          freeze_i,
    bp_be_scoreboard_detector_if.slave    isd,
    input  logic                          mem_ret_i,
    input  logic                          flush_i,
    input  logic                          fe_cmd_ready_i,
    input  logic                          mmu_cmd_ready_i,
    input  logic                          long_busy_i,
    output logic                          credits_full_o,
    output logic                          credits_empty_o
);

    localparam int lat_w_lp  = `BP_BE_CNT_W(max_lat_p);
    localparam int ser_w_lp  = `BP_BE_CNT_W(serial_stages_p);
    localparam int shd_w_lp  = `BP_BE_CNT_W(pipe_depth_p);
    localparam int cred_w_lp = `BP_BE_CNT_W(credits_p);

    logic                upd;
    logic                iwb_ld, fwb_ld;
    logic [2:0]          ibusy, fbusy;
    logic [lat_w_lp-1:0] icnt_rd, fcnt_rd;
    logic                unused_ibusy2;

    logic [ser_w_lp-1:0]  ser_q, ser_d;
    logic [shd_w_lp-1:0]  shadow_q, shadow_d;
    logic [cred_w_lp-1:0] cred_q, cred_d;
    logic                 cred_inc, cred_dec;

    logic              raw, waw, ctrl, strct, fence_wait;
    logic [HAZ_W-1:0]  haz;

    // Only a permitted offer outside a flush cycle changes any state.
    assign upd    = isd.isd_v_i & isd.chk_dispatch_v_o & ~flush_i;
    assign iwb_ld = upd & isd.isd_iwb_v_i & (isd.isd_rd_addr_i != '0);
    assign fwb_ld = upd & isd.isd_fwb_v_i;

    bp_be_reg_scoreboard #(
        .addr_w_p(reg_addr_width_p), .lat_w_p(lat_w_lp), .zero_reg_p(1'b1)
    ) u_int_sb (
        .clk_i, .reset_n_i, .flush_i,
        .ld_v_i(iwb_ld), .ld_addr_i(isd.isd_rd_addr_i), .ld_lat_i(isd.isd_lat_i),
        .rs_addr_i(isd.isd_rs_addr_i), .rs_busy_o(ibusy),
        .rd_addr_i(isd.isd_rd_addr_i), .rd_cnt_o(icnt_rd)
    );

    bp_be_reg_scoreboard #(
        .addr_w_p(reg_addr_width_p), .lat_w_p(lat_w_lp), .zero_reg_p(1'b0)
    ) u_fp_sb (
        .clk_i, .reset_n_i, .flush_i,
        .ld_v_i(fwb_ld), .ld_addr_i(isd.isd_rd_addr_i), .ld_lat_i(isd.isd_lat_i),
        .rs_addr_i(isd.isd_rs_addr_i), .rs_busy_o(fbusy),
        .rd_addr_i(isd.isd_rd_addr_i), .rd_cnt_o(fcnt_rd)
    );

    assign unused_ibusy2 = ibusy[2];

    assign cred_inc = upd & isd.isd_mem_v_i;
    assign cred_dec = mem_ret_i;

    always_comb begin
        ser_d = (ser_q != '0) ? ser_q - ser_w_lp'(1) : '0;
        if (upd && isd.isd_serial_v_i) ser_d = ser_w_lp'(serial_stages_p);
        if (flush_i)                   ser_d = '0;

        shadow_d = (shadow_q != '0) ? shadow_q - shd_w_lp'(1) : '0;
        if (cred_inc) shadow_d = shd_w_lp'(pipe_depth_p);
        if (flush_i)  shadow_d = '0;

        // Credits survive flush: already-issued memory ops still return.
        cred_d = cred_q;
        if (cred_inc && !cred_dec)
            cred_d = cred_q + cred_w_lp'(1);
        else if (!cred_inc && cred_dec && (cred_q != '0))
            cred_d = cred_q - cred_w_lp'(1);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ser_q    <= '0;
            shadow_q <= '0;
            cred_q   <= '0;
        end else begin
            ser_q    <= ser_d;
            shadow_q <= shadow_d;
            cred_q   <= cred_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_n_i)
            assert (!(cred_dec && !cred_inc && (cred_q == '0)));
    end

    assign credits_full_o  = (cred_q == cred_w_lp'(credits_p));
    assign credits_empty_o = (cred_q == '0);

    assign raw = |(isd.isd_irs_v_i & ibusy[1:0]) | |(isd.isd_frs_v_i & fbusy);
    assign waw = (isd.isd_iwb_v_i & (isd.isd_rd_addr_i != '0) & (icnt_rd > isd.isd_lat_i))
               | (isd.isd_fwb_v_i & (fcnt_rd > isd.isd_lat_i));

    assign fence_wait = isd.isd_fence_v_i & ~(credits_empty_o & (shadow_q == '0));
    assign ctrl  = (ser_q != '0) | fence_wait | long_busy_i;
    assign strct = freeze_i | ~mmu_cmd_ready_i | ~fe_cmd_ready_i
                 | (isd.isd_mem_v_i & credits_full_o);

    always_comb begin
        haz             = '0;
        haz[HAZ_RAW]    = raw;
        haz[HAZ_WAW]    = waw;
        haz[HAZ_CTRL]   = ctrl;
        haz[HAZ_STRUCT] = strct;
    end

    assign isd.haz_o            = haz;
    assign isd.chk_dispatch_v_o = ~|haz;

endmodule

// File: tb/tb_bp_be_scoreboard_detector.sv
// Directed scoreboard bench: each cycle's expected permit/hazard/credit flags
// are queued when stimulus is applied and compared at the following negedge.
module tb_bp_be_scoreboard_detector;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, freeze, mem_ret, flush, fe_rdy, mmu_rdy, long_busy;
    logic full, empty;

    bp_be_scoreboard_detector_if #(.reg_addr_width_p(5), .max_lat_p(7)) bus ();

    bp_be_scoreboard_detector dut (
        .clk_i          (clk),
        .reset_n_i      (reset_n),
        .freeze_i       (freeze),
        .isd            (bus),
        .mem_ret_i      (mem_ret),
        .flush_i        (flush),
        .fe_cmd_ready_i (fe_rdy),
        .mmu_cmd_ready_i(mmu_rdy),
        .long_busy_i    (long_busy),
        .credits_full_o (full),
        .credits_empty_o(empty)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [6:0] exp_q[$];

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.isd_v_i        = 1'b0;
        bus.isd_rs_addr_i  = '0;
        bus.isd_irs_v_i    = '0;
        bus.isd_frs_v_i    = '0;
        bus.isd_rd_addr_i  = '0;
        bus.isd_iwb_v_i    = 1'b0;
        bus.isd_fwb_v_i    = 1'b0;
        bus.isd_lat_i      = '0;
        bus.isd_mem_v_i    = 1'b0;
        bus.isd_fence_v_i  = 1'b0;
        bus.isd_serial_v_i = 1'b0;
        freeze    = 1'b0;
        mem_ret   = 1'b0;
        flush     = 1'b0;
        fe_rdy    = 1'b1;
        mmu_rdy   = 1'b1;
        long_busy = 1'b0;
    endtask

    // Expect {dispatch, haz[3:0], full, empty} for the cycle just driven.
    task automatic step(input string tag, input logic c, input logic [3:0] h,
                        input logic f, input logic e);
        logic [6:0] x;
        exp_q.push_back({c, h, f, e});
        @(negedge clk);
        x = exp_q.pop_front();
        check({tag, ".dv"},    8'(bus.chk_dispatch_v_o), 8'(x[6]));
        check({tag, ".haz"},   8'(bus.haz_o),            8'(x[5:2]));
        check({tag, ".full"},  8'(full),                 8'(x[1]));
        check({tag, ".empty"}, 8'(empty),                8'(x[0]));
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic iwb, input logic fwb, input logic [4:0] rd, input logic [2:0] lat);
        idle();
        bus.isd_v_i = 1'b1; bus.isd_iwb_v_i = iwb; bus.isd_fwb_v_i = fwb;
        bus.isd_rd_addr_i = rd; bus.isd_lat_i = lat;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        idle();
        bus.isd_v_i = 1'b1; bus.isd_mem_v_i = 1'b1;
        step("rst_idle", 1, 4'b0000, 0, 1);
        idle(); freeze = 1'b1;
        step("rst_frz", 0, 4'b1000, 0, 1);
        idle(); long_busy = 1'b1;
        step("rst_lb", 0, 4'b0100, 0, 1);
        idle(); fe_rdy = 1'b0;
        step("rst_fe", 0, 4'b1000, 0, 1);
        reset_n = 1'b1;

        // RAW on x5 (lat 2) via rs1, then x6 (lat 1) via rs2
        wr(1, 0, 5'd5, 3'd2);                    step("raw_ld", 1, 4'b0000, 0, 1);
        idle(); bus.isd_v_i = 1; bus.isd_irs_v_i = 2'b01; bus.isd_rs_addr_i[0] = 5'd5;
        step("raw_s1", 0, 4'b0001, 0, 1);
        step("raw_s2", 0, 4'b0001, 0, 1);
        step("raw_go", 1, 4'b0000, 0, 1);
        wr(1, 0, 5'd6, 3'd1);                    step("raw2_ld", 1, 4'b0000, 0, 1);
        idle(); bus.isd_v_i = 1; bus.isd_irs_v_i = 2'b10; bus.isd_rs_addr_i[1] = 5'd6;
        step("raw2_s", 0, 4'b0001, 0, 1);
        step("raw2_go", 1, 4'b0000, 0, 1);

        // WAW on f3: lat 4 then lat 1; then rs3 read of f3
        wr(0, 1, 5'd3, 3'd4);                    step("waw_ld", 1, 4'b0000, 0, 1);
        wr(0, 1, 5'd3, 3'd1);
        for (int k = 0; k < 3; k++) step("waw_s", 0, 4'b0010, 0, 1);
        step("waw_go", 1, 4'b0000, 0, 1);
        idle(); bus.isd_v_i = 1; bus.isd_frs_v_i = 3'b100; bus.isd_rs_addr_i[2] = 5'd3;
        step("fma_s", 0, 4'b0001, 0, 1);
        step("fma_go", 1, 4'b0000, 0, 1);
        // WAW boundary: cnt equal to new latency is allowed
        wr(0, 1, 5'd4, 3'd3);                    step("wawb_ld", 1, 4'b0000, 0, 1);
        wr(0, 1, 5'd4, 3'd2);                    step("wawb_s", 0, 4'b0010, 0, 1);
        step("wawb_go", 1, 4'b0000, 0, 1);

        // x0 is never busy
        wr(1, 0, 5'd0, 3'd5);                    step("x0_ld", 1, 4'b0000, 0, 1);
        wr(1, 0, 5'd0, 3'd0); bus.isd_irs_v_i = 2'b11;
        step("x0_rd", 1, 4'b0000, 0, 1);

        // Credits: fill to 8, stall, return/concurrent, drain
        for (int k = 0; k < 8; k++) begin
            idle(); bus.isd_v_i = 1; bus.isd_mem_v_i = 1;
            step("cr_fill", 1, 4'b0000, 0, k == 0);
        end
        step("cr_full", 0, 4'b1000, 1, 0);
        idle(); mem_ret = 1;                     step("cr_ret", 1, 4'b0000, 1, 0);
        idle(); bus.isd_v_i = 1; bus.isd_mem_v_i = 1; mem_ret = 1;
        step("cr_both", 1, 4'b0000, 0, 0);
        idle(); bus.isd_v_i = 1; bus.isd_mem_v_i = 1;
        step("cr_inc", 1, 4'b0000, 0, 0);
        idle();                                  step("cr_full2", 1, 4'b0000, 1, 0);
        for (int k = 0; k < 8; k++) begin
            idle(); mem_ret = 1;
            step("cr_drain", 1, 4'b0000, k == 0, 0);
        end
        idle();                                  step("cr_empty", 1, 4'b0000, 0, 1);

        // Fence after two mem ops waits for credits and the mem shadow
        idle(); bus.isd_v_i = 1; bus.isd_mem_v_i = 1; step("fn_m1", 1, 4'b0000, 0, 1);
        step("fn_m2", 1, 4'b0000, 0, 0);
        idle(); bus.isd_v_i = 1; bus.isd_fence_v_i = 1;
        step("fn_w0", 0, 4'b0100, 0, 0);
        mem_ret = 1;                             step("fn_w1", 0, 4'b0100, 0, 0);
        step("fn_w2", 0, 4'b0100, 0, 0);
        mem_ret = 0;                             step("fn_shd", 0, 4'b0100, 0, 1);
        step("fn_go", 1, 4'b0000, 0, 1);

        // Serial: blocks four cycles
        idle(); bus.isd_v_i = 1; bus.isd_serial_v_i = 1;
        step("ser_ld", 1, 4'b0000, 0, 1);
        idle(); bus.isd_v_i = 1;
        for (int k = 0; k < 4; k++) step("ser_s", 0, 4'b0100, 0, 1);
        step("ser_go", 1, 4'b0000, 0, 1);
        // Serial then flush next cycle
        idle(); bus.isd_v_i = 1; bus.isd_serial_v_i = 1;
        step("sfl_ld", 1, 4'b0000, 0, 1);
        idle(); bus.isd_v_i = 1; flush = 1;      step("sfl_fl", 0, 4'b0100, 0, 1);
        idle(); bus.isd_v_i = 1;                 step("sfl_go", 1, 4'b0000, 0, 1);
        // Flush clears scoreboards and drops the flush-cycle dispatch
        wr(1, 0, 5'd10, 3'd6);                   step("fl_ld", 1, 4'b0000, 0, 1);
        wr(1, 0, 5'd11, 3'd7); bus.isd_mem_v_i = 1; flush = 1;
        step("fl_cyc", 1, 4'b0000, 0, 1);
        idle(); bus.isd_v_i = 1; bus.isd_irs_v_i = 2'b11;
        bus.isd_rs_addr_i[0] = 5'd10; bus.isd_rs_addr_i[1] = 5'd11;
        step("fl_rd", 1, 4'b0000, 0, 1);

        // Async reset mid-operation
        wr(1, 0, 5'd7, 3'd3); bus.isd_mem_v_i = 1;
        step("ar_ld", 1, 4'b0000, 0, 1);
        idle(); bus.isd_v_i = 1; bus.isd_irs_v_i = 2'b01; bus.isd_rs_addr_i[0] = 5'd7;
        step("ar_s", 0, 4'b0001, 0, 0);
        reset_n = 1'b0;
        step("ar_rst", 1, 4'b0000, 0, 1);
        reset_n = 1'b1;
        step("ar_go", 1, 4'b0000, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
